// File: rtl/aes_serial_seq_if.sv
// Host-side block handshake for the byte-serial AES sequencer:
// block start/busy/done plus valid/ready byte streaming on load and drain.
interface aes_serial_seq_if;
  logic start;
  logic busy;
  logic in_vld;
  logic in_rdy;
  logic out_vld;
  logic out_rdy;
  logic done;

  // host / byte stream side
  modport master (
    output start, in_vld, out_rdy,
    input  busy, in_rdy, out_vld, done
  );

  // sequencer side
  modport slave (
    input  start, in_vld, out_rdy,
    output busy, in_rdy, out_vld, done
  );
endinterface

// File: rtl/aes_serial_seq.sv
// Sequencer for the byte-serial AES engine. One FSM walks LOAD, NUM_ROUNDS
// 16-cycle rounds and DRAIN, and decodes the key-expansion mux selects.
// Back-pressure on load/drain gates the key/data path through core_ce.
// Optional: define AES_SEQ_PERF_CNT_EN to add blk_cnt / stall_cnt counters.
module aes_serial_seq #(
  parameter int NUM_ROUNDS  = 10,
  parameter int LOAD_BYTES  = 16,
  parameter int DRAIN_BYTES = 16,
  parameter int RW          = 4
) (
  input  logic          clk,
  input  logic          rst,
  aes_serial_seq_if.slave bus,
  output logic          core_ce,
  output logic          input_sel,
  output logic          sbox_sel,
  output logic          last_out_sel,
  output logic          bit_out_sel,
  output logic          rcon_en,
  output logic [3:0]    byte_idx,
  output logic [RW-1:0] round_idx,
  output logic          last_round
`ifdef AES_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]   blk_cnt,
  output logic [31:0]   stall_cnt
`endif
);

  typedef enum logic [2:0] {
    IDLE, LOAD, B1ST, B2ND, B3RD, NORM, SHIF, DRAIN
  } state_t;

  localparam logic [3:0]    LOAD_LAST  = 4'(LOAD_BYTES - 1);
  localparam logic [3:0]    DRAIN_LAST = 4'(DRAIN_BYTES - 1);
  localparam logic [RW-1:0] ROUND_LAST = RW'(NUM_ROUNDS);

  state_t        state;
  logic [3:0]    byte_q;
  logic [RW-1:0] round_q;
  logic          done_q;
  logic          in_round;

  // Main sequencing FSM: state, byte/round counters and the done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      byte_q  <= '0;
      round_q <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state  <= LOAD;
            byte_q <= '0;
          end
        end
        LOAD: begin
          if (bus.in_vld) begin
            if (byte_q == LOAD_LAST) begin
              state   <= B1ST;
              byte_q  <= '0;
              round_q <= RW'(1);
            end else begin
              byte_q <= byte_q + 4'd1;
            end
          end
        end
        B1ST: begin
          state  <= B2ND;
          byte_q <= byte_q + 4'd1;
        end
        B2ND: begin
          if (byte_q == 4'd2) state <= B3RD;
          byte_q <= byte_q + 4'd1;
        end
        B3RD: begin
          state  <= NORM;
          byte_q <= byte_q + 4'd1;
        end
        NORM: begin
          if (byte_q == 4'd11) state <= SHIF;
          byte_q <= byte_q + 4'd1;
        end
        SHIF: begin
          if (byte_q == 4'd15) begin
            byte_q <= '0;
            if (round_q < ROUND_LAST) begin
              state   <= B1ST;
              round_q <= round_q + RW'(1);
            end else begin
              state   <= DRAIN;
              round_q <= '0;
            end
          end else begin
            byte_q <= byte_q + 4'd1;
          end
        end
        DRAIN: begin
          if (bus.out_rdy) begin
            if (byte_q == DRAIN_LAST) begin
              state  <= IDLE;
              byte_q <= '0;
              done_q <= 1'b1;
            end else begin
              byte_q <= byte_q + 4'd1;
            end
          end
        end
        default: begin
          state   <= IDLE;
          byte_q  <= '0;
          round_q <= '0;
        end
      endcase
    end
  end

  // Output decode from registered state; only core_ce sees in_vld/out_rdy.
  always_comb begin
    in_round = (state == B1ST) || (state == B2ND) || (state == B3RD) ||
               (state == NORM) || (state == SHIF);
    core_ce  = 1'b0;
    {input_sel, sbox_sel, last_out_sel, bit_out_sel, rcon_en} = 5'b01000;
    case (state)
      LOAD:  core_ce = bus.in_vld;
      DRAIN: core_ce = bus.out_rdy;
      B1ST: begin
        core_ce = 1'b1;
        {input_sel, sbox_sel, last_out_sel, bit_out_sel, rcon_en} = 5'b11011;
      end
      B2ND: begin
        core_ce = 1'b1;
        {input_sel, sbox_sel, last_out_sel, bit_out_sel, rcon_en} = 5'b11010;
      end
      B3RD: begin
        core_ce = 1'b1;
        {input_sel, sbox_sel, last_out_sel, bit_out_sel, rcon_en} = 5'b10010;
      end
      NORM: begin
        core_ce = 1'b1;
        {input_sel, sbox_sel, last_out_sel, bit_out_sel, rcon_en} = 5'b10110;
      end
      SHIF: begin
        core_ce = 1'b1;
        {input_sel, sbox_sel, last_out_sel, bit_out_sel, rcon_en} = 5'b10100;
      end
      default: ;
    endcase
  end

  assign bus.busy    = (state != IDLE);
  assign bus.in_rdy  = (state == LOAD);
  assign bus.out_vld = (state == DRAIN);
  assign bus.done    = done_q;
  assign byte_idx    = byte_q;
  assign round_idx   = round_q;
  // final round skips MixColumns downstream
  assign last_round  = in_round && (round_q == ROUND_LAST);

`ifdef AES_SEQ_PERF_CNT_EN
  // Completed-block and back-pressure stall counters, free-wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      blk_cnt   <= '0;
      stall_cnt <= '0;
    end else begin
      if (done_q) blk_cnt <= blk_cnt + 32'd1;
      if (((state == LOAD) || (state == DRAIN)) && !core_ce)
        stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_aes_serial_seq.sv
// Bench for aes_serial_seq: a phase/counter reference model predicts every
// cycle's outputs into a queue; a negedge monitor pops and compares. Block
// latency expectations go through a second queue checked on each done.
module tb_aes_serial_seq;
  localparam int NR = 10;
  localparam int LB = 16;
  localparam int DB = 16;

  logic clk, rst;
  logic core_ce, input_sel, sbox_sel, last_out_sel, bit_out_sel, rcon_en, last_round;
  logic [3:0] byte_idx;
  logic [3:0] round_idx;
`ifdef AES_SEQ_PERF_CNT_EN
  logic [31:0] blk_cnt, stall_cnt;
`endif

  aes_serial_seq_if bus();

  aes_serial_seq #(.NUM_ROUNDS(NR), .LOAD_BYTES(LB), .DRAIN_BYTES(DB), .RW(4)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .core_ce(core_ce), .input_sel(input_sel), .sbox_sel(sbox_sel),
    .last_out_sel(last_out_sel), .bit_out_sel(bit_out_sel), .rcon_en(rcon_en),
    .byte_idx(byte_idx), .round_idx(round_idx), .last_round(last_round)
`ifdef AES_SEQ_PERF_CNT_EN
    , .blk_cnt(blk_cnt), .stall_cnt(stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic busy, in_rdy, out_vld, done, core_ce;
    logic input_sel, sbox_sel, last_out_sel, bit_out_sel, rcon_en, last_round;
    logic [3:0] byte_idx;
    logic [3:0] round_idx;
  } obs_t;

  typedef struct {
    int          cyc;
    obs_t        o;
    logic [31:0] blk;
    logic [31:0] stall;
  } exp_t;

  typedef struct { int st; int ovld; int done; } lat_t;

  exp_t exp_q[$];
  lat_t lat_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  bit fin = 0, fin_done = 0;

  // reference model: phase + position counter
  typedef enum {P_IDLE, P_LOAD, P_RND, P_DRAIN} ph_t;
  ph_t ph = P_IDLE;
  int cnt = 0;
  bit dpend = 0, known = 0;
  int cyc = 0;
  logic [31:0] m_blk = 0, m_stall = 0;

  function automatic obs_t predict(input logic iv, input logic orr);
    obs_t o;
    logic [4:0] sel;
    int idx, r;
    o = '0;
    sel = 5'b01000;
    o.busy = (ph != P_IDLE);
    o.done = dpend;
    case (ph)
      P_LOAD: begin o.in_rdy = 1; o.core_ce = iv; o.byte_idx = 4'(cnt); end
      P_DRAIN: begin o.out_vld = 1; o.core_ce = orr; o.byte_idx = 4'(cnt); end
      P_RND: begin
        idx = cnt % 16;
        r = cnt / 16 + 1;
        o.core_ce = 1;
        o.byte_idx = 4'(idx);
        o.round_idx = 4'(r);
        o.last_round = (r == NR);
        if (idx == 0) sel = 5'b11011;
        else if (idx <= 2) sel = 5'b11010;
        else if (idx == 3) sel = 5'b10010;
        else if (idx <= 11) sel = 5'b10110;
        else sel = 5'b10100;
      end
      default: ;
    endcase
    {o.input_sel, o.sbox_sel, o.last_out_sel, o.bit_out_sel, o.rcon_en} = sel;
    return o;
  endfunction

  task automatic step(input logic s, input logic iv, input logic orr, input logic r);
    exp_t e;
    @(posedge clk); #1;
    bus.start = s; bus.in_vld = iv; bus.out_rdy = orr; rst = r;
    if (known) begin
      e.cyc = cyc; e.o = predict(iv, orr); e.blk = m_blk; e.stall = m_stall;
      exp_q.push_back(e);
    end
    if (r) begin
      ph = P_IDLE; cnt = 0; dpend = 0; m_blk = 0; m_stall = 0; known = 1;
    end else if (known) begin
      if (dpend) m_blk = m_blk + 1;
      if ((ph == P_LOAD && !iv) || (ph == P_DRAIN && !orr)) m_stall = m_stall + 1;
      dpend = 0;
      case (ph)
        P_IDLE: if (s) begin ph = P_LOAD; cnt = 0; end
        P_LOAD: if (iv) begin
          if (cnt == LB - 1) begin ph = P_RND; cnt = 0; end else cnt++;
        end
        P_RND: if (cnt == 16 * NR - 1) begin ph = P_DRAIN; cnt = 0; end else cnt++;
        P_DRAIN: if (orr) begin
          if (cnt == DB - 1) begin ph = P_IDLE; cnt = 0; dpend = 1; end else cnt++;
        end
        default: ;
      endcase
    end
    cyc++;
  endtask

  // One block from IDLE, with optional load stall (at beat ls_at for ls_n
  // cycles) and drain stall (at beat 0 for ds_n cycles).
  task automatic run_block(input int ls_at, input int ls_n, input int ds_n);
    lat_t l;
    int k, lsl, dsl;
    logic iv, orr;
    l.st = cyc;
    l.ovld = 1 + LB + 16 * NR + ls_n;
    l.done = l.ovld + DB + ds_n;
    lat_q.push_back(l);
    step(1, 1, 1, 0);
    lsl = ls_n; dsl = ds_n; k = 0;
    while (!(ph == P_IDLE && !dpend) && k < 3000) begin
      iv = 1; orr = 1;
      if (ph == P_LOAD && cnt == ls_at && lsl > 0) begin iv = 0; lsl--; end
      if (ph == P_DRAIN && cnt == 0 && dsl > 0) begin orr = 0; dsl--; end
      step(0, iv, orr, 0);
      k++;
    end
    if (k >= 3000) begin
      $display("FAIL block_timeout: got no return to idle within %0d cycles, required %0d", k, l.done);
      $fatal(1, "block timeout");
    end
  endtask

  // Monitor: per-cycle trace compare, latency check on each done.
  obs_t a;
  exp_t e_m;
  lat_t l_m;
  bit prev_ov = 0;
  int ovld_c = 0;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e_m = exp_q.pop_front();
      a = {bus.busy, bus.in_rdy, bus.out_vld, bus.done, core_ce,
           input_sel, sbox_sel, last_out_sel, bit_out_sel, rcon_en, last_round,
           byte_idx, round_idx};
      n_cmp++;
      if (a !== e_m.o) begin
        n_bad++;
        $display("FAIL trace cyc=%0d got=%b required=%b", e_m.cyc, a, e_m.o);
      end
`ifdef AES_SEQ_PERF_CNT_EN
      n_cmp++;
      if (blk_cnt !== e_m.blk || stall_cnt !== e_m.stall) begin
        n_bad++;
        $display("FAIL perf cyc=%0d got blk=%0d stall=%0d required blk=%0d stall=%0d",
                 e_m.cyc, blk_cnt, stall_cnt, e_m.blk, e_m.stall);
      end
`endif
      if (a.out_vld && !prev_ov) ovld_c = e_m.cyc;
      prev_ov = a.out_vld;
      if (a.done && lat_q.size() > 0) begin
        l_m = lat_q.pop_front();
        n_cmp++;
        if (ovld_c - l_m.st != l_m.ovld) begin
          n_bad++;
          $display("FAIL first_out_vld_latency got=%0d required=%0d", ovld_c - l_m.st, l_m.ovld);
        end
        n_cmp++;
        if (e_m.cyc - l_m.st != l_m.done) begin
          n_bad++;
          $display("FAIL done_latency got=%0d required=%0d", e_m.cyc - l_m.st, l_m.done);
        end
      end
    end
    if (fin && !fin_done) begin
      n_cmp++;
      if (exp_q.size() != 0 || lat_q.size() != 0) begin
        n_bad++;
        $display("FAIL drain_queues got exp=%0d lat=%0d required 0/0", exp_q.size(), lat_q.size());
      end
      fin_done = 1;
    end
  end

  initial begin
    int k;
    rst = 1; bus.start = 0; bus.in_vld = 0; bus.out_rdy = 0;
    repeat (3) step(0, 0, 0, 1);
    repeat (2) step(0, 1, 1, 0);
    // nominal, load stall, drain stall
    run_block(-1, 0, 0);
    step(0, 1, 1, 0);
    run_block(6, 3, 0);
    step(0, 1, 1, 0);
    run_block(-1, 0, 2);
    step(0, 1, 1, 0);
    // reset during NORM of round 4, then nominal block
    step(1, 1, 1, 0);
    k = 0;
    while (!(ph == P_RND && cnt == 3 * 16 + 6) && k < 1000) begin step(0, 1, 1, 0); k++; end
    step(0, 1, 1, 1);
    repeat (2) step(0, 1, 1, 0);
    run_block(-1, 0, 0);
    // start held high: back-to-back blocks
    step(0, 1, 1, 1);
    repeat (2 * (1 + LB + 16 * NR + DB) + 3) step(1, 1, 1, 0);
    step(0, 1, 1, 0);
    // randomized traffic
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 2) == 0, $urandom_range(0, 9) < 7,
           $urandom_range(0, 9) < 7, $urandom_range(0, 599) == 0);
    repeat (4) step(0, 0, 0, 0);
    fin = 1;
    k = 0;
    while (!fin_done && k < 20) begin @(posedge clk); k++; end
    if (!fin_done) begin
      $display("FAIL monitor_finish: got no final check, required one");
      $fatal(1, "monitor stalled");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/aes_serial_seq.md
Name: aes_serial_seq

Overview:
- Parametrised sequencer for the byte-serial AES engine. It drives the key-expansion and data-path mux selects from a single state machine.
- Replaces the fixed 10-round, free-running top-level controller.
- Adds three things the fixed controller lacks: a start/done block handshake, valid/ready byte streaming on load and drain (back-pressure gates the core through a clock enable), and a configurable round count.
- Sits between the host byte stream and the key_expansion / aes_data_path instances.

Parameters:
NUM_ROUNDS, 10, number of 16-cycle rounds per block (10/12/14 legal; 1..15 must work)
LOAD_BYTES, 16, byte beats accepted per block load
DRAIN_BYTES, 16, byte beats presented per block output
RW, 4, width of round_idx (must hold NUM_ROUNDS)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  begin a block; sampled only in IDLE
busy  out  1  high whenever state != IDLE
in_vld  in  1  key/data byte valid during load
in_rdy  out  1  high in LOAD
out_vld  out  1  ciphertext byte valid, high in DRAIN
out_rdy  in  1  downstream accepts byte
done  out  1  one-cycle pulse after final drain beat
core_ce  out  1  clock enable for key/data path registers
input_sel  out  1  key-expansion input mux
sbox_sel  out  1  key-expansion sbox mux
last_out_sel  out  1  key-expansion last-column mux
bit_out_sel  out  1  key-expansion output mux
rcon_en  out  1  apply round constant
byte_idx  out  4  position within load/round/drain
round_idx  out  RW  current round, 1..NUM_ROUNDS; 0 in IDLE/LOAD/DRAIN
last_round  out  1  round_idx == NUM_ROUNDS in round states (skip MixColumns)

Behaviour:
- States: IDLE, LOAD, B1ST, B2ND, B3RD, NORM, SHIF, DRAIN.
- Reset: state IDLE, byte_idx 0, round_idx 0. All 1-bit outputs are 0, except sbox_sel=1 (IDLE select values).
- IDLE: core_ce 0. start=1 -> LOAD, byte_idx 0.
- LOAD: in_rdy 1; core_ce = in_vld. byte_idx increments per accepted beat.
  - Beat LOAD_BYTES-1 accepted -> B1ST, byte_idx 0, round_idx 1.
  - in_vld low holds all state.
- Round states: core_ce 1, byte_idx increments every cycle, 16 cycles per round.
  - B1ST: idx 0. B2ND: idx 1-2. B3RD: idx 3. NORM: idx 4-11. SHIF: idx 12-15.
- At SHIF idx 15:
  - round_idx < NUM_ROUNDS -> round_idx+1, B1ST.
  - Otherwise -> DRAIN, byte_idx 0, round_idx 0.
- Selects (input_sel, sbox_sel, last_out_sel, bit_out_sel, rcon_en):
  - IDLE/LOAD/DRAIN: 0,1,0,0,0
  - B1ST: 1,1,0,1,1
  - B2ND: 1,1,0,1,0
  - B3RD: 1,0,0,1,0
  - NORM: 1,0,1,1,0
  - SHIF: 1,0,1,0,0
- DRAIN: out_vld 1; core_ce = out_rdy. byte_idx increments per accepted beat.
  - Beat DRAIN_BYTES-1 accepted -> IDLE; done = 1 in the next cycle only.
- start is ignored outside IDLE. start held high through done begins the next block in the cycle after the IDLE entry.
- Latency, NUM_ROUNDS=10, no stalls, start sampled at cycle 0:
  - LOAD cycles 1-16.
  - Rounds cycles 17-176.
  - First out_vld cycle 177; last drain beat cycle 192; done cycle 193.
  - General: first out_vld = 1 + LOAD_BYTES + 16*NUM_ROUNDS.
- All outputs are combinational decodes of registered state/counters: no comb path from in_vld/out_rdy except core_ce.
- rst mid-operation: IDLE on the next edge, counters cleared, no done pulse.
- Illegal state encoding: recover to IDLE.

Optional Feature:
- AES_SEQ_PERF_CNT_EN defined:
  - Adds outputs blk_cnt[31:0] (increments on done) and stall_cnt[31:0] (increments on each LOAD or DRAIN cycle with core_ce 0).
  - Both clear on rst and wrap at 2^32.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then start=1 for one cycle with in_vld/out_rdy held 1 -> in_rdy cycles 1-16; B1ST at 17 with rcon_en=1; out_vld cycles 177-192; done only at 193; busy drops at 193.
- in_vld low for 3 cycles after beat 5 -> core_ce 0 and byte_idx held at 6 for those cycles; first out_vld moves to cycle 180.
- out_rdy low for 2 cycles at drain beat 0 -> out_vld stays 1, byte_idx 0, core_ce 0; done at cycle 195.
- NUM_ROUNDS=14 -> round_idx sequences 1..14; last_round high only in cycles 225-240; first out_vld at cycle 241.
- rst asserted during NORM of round 4 -> next cycle IDLE, busy 0, round_idx 0, no done; a new start then gives nominal timing.
- start held high continuously, two blocks -> second LOAD begins the cycle after first done; with AES_SEQ_PERF_CNT_EN, blk_cnt=2 and stall_cnt=0 after the second done.
